// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage pipeline control slice: controller state
// encodings, forwarding-select codes, register-address width and the
// valid-bit positions of the pipeline registers in the datapath.
package pipe_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Valid-bit positions inside the datapath pipeline registers.
  localparam int IFID_VALID_BIT  = 64;
  localparam int IDEX_VALID_BIT  = 148;
  localparam int EXMEM_VALID_BIT = 108;
  localparam int MEMWB_VALID_BIT = 72;

endpackage

// File: rtl/pipe_fwd_unit.sv
// Purely combinational EX operand forwarding compare for both operand paths.
// The younger producer (MEM) wins over WB; register 0 is never forwarded.
module pipe_fwd_unit #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);
  import pipe_pkg::FWD_REG;
  import pipe_pkg::FWD_EXMEM;
  import pipe_pkg::FWD_MEMWB;

  function automatic logic [1:0] pick(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] m_rd,
    input logic              m_we,
    input logic [REG_AW-1:0] w_rd,
    input logic              w_we
  );
    logic [1:0] sel;
    sel = FWD_REG;
    if (m_we && (m_rd != '0) && (m_rd == src)) begin
      sel = FWD_EXMEM;
    end else if (w_we && (w_rd != '0) && (w_rd == src)) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

  // Select the freshest in-flight copy of each source operand.
  always_comb begin
    fwd_a = pick(rs, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    fwd_b = pick(rt, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard / sequencing controller for the IF/ID/EX/MEM/WB pipeline.
// Produces PC and pipeline-register hold/bubble/flush controls, the EX
// forwarding selects, and runs the halt drain (RUN -> DRAIN -> HALTED).
// Optional performance counters are built when PIPE_PERF_EN is defined.
// Priority of events: branch_taken > load-use stall > halt.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int REG_AW       = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_halt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  input  logic              branch_taken,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              halted,
  output logic [1:0]        state_o
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0]       cyc_cnt,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);
  import pipe_pkg::state_e;
  import pipe_pkg::RUN;
  import pipe_pkg::DRAIN;
  import pipe_pkg::HALTED;
  import pipe_pkg::FWD_REG;

  localparam int              CW         = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0]   DRAIN_LOAD = CW'(DRAIN_CYCLES);
  localparam logic [CW-1:0]   DRAIN_LAST = CW'(1);

  state_e          state;
  logic [CW-1:0]   drain_cnt;
  logic [1:0]      fwd_a_raw;
  logic [1:0]      fwd_b_raw;
  logic            load_use;
  logic            stall_now;

  // Load in EX whose result the ID instruction needs next cycle.
  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((id_use_rs && (ex_rd == id_rs)) ||
                     (id_use_rt && (ex_rd == id_rt)));

  pipe_fwd_unit #(.REG_AW(REG_AW)) u_fwd (
    .rs           (id_rs),
    .rt           (id_rt),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .fwd_a        (fwd_a_raw),
    .fwd_b        (fwd_b_raw)
  );

  // Halt sequencing FSM; halted is a registered flag set on entry to HALTED.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= RUN;
      drain_cnt <= '0;
      halted    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (id_halt && !branch_taken && !load_use) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (branch_taken) begin
            // An older branch squashes the halt behind it.
            state     <= RUN;
            drain_cnt <= '0;
          end else if (drain_cnt == DRAIN_LAST) begin
            state     <= HALTED;
            drain_cnt <= '0;
            halted    <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state     <= RUN;
          drain_cnt <= '0;
          halted    <= 1'b0;
        end
      endcase
    end
  end

  // Pipeline control outputs decoded from state and the current hazards.
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    fwd_a       = fwd_a_raw;
    fwd_b       = fwd_b_raw;
    stall_now   = 1'b0;
    case (state)
      RUN: begin
        if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end else if (load_use) begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
          stall_now   = 1'b1;
        end
      end
      DRAIN: begin
        // Fetch is frozen and IF/ID squashed while older work retires.
        ifid_flush = 1'b1;
        if (branch_taken) begin
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end else begin
          pc_hold = 1'b1;
        end
      end
      HALTED: begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
        fwd_a       = FWD_REG;
        fwd_b       = FWD_REG;
      end
      default: begin
        pc_hold = 1'b0;
      end
    endcase
  end

  assign state_o = state;

`ifdef PIPE_PERF_EN
  // Performance counters; frozen once the pipeline has halted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!halted) begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (stall_now) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (branch_taken) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`else
  logic unused_stall;
  assign unused_stall = stall_now;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a table of single-cycle vectors,
// hand-written multi-cycle sequences (load-use, halt drain, branch during
// drain, asynchronous reset) and randomized traffic against a reference model.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_halt;
    logic [4:0] ex_rd;
    logic       ex_regwrite;
    logic       ex_memread;
    logic [4:0] mem_rd;
    logic       mem_regwrite;
    logic [4:0] wb_rd;
    logic       wb_regwrite;
    logic       branch_taken;
  } in_t;

  typedef struct packed {
    logic       pc_hold;
    logic       ifid_hold;
    logic       idex_bubble;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic [1:0] state;
    logic       halted;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs, id_use_rt, id_halt, ex_regwrite, ex_memread;
  logic       mem_regwrite, wb_regwrite, branch_taken;
  logic       pc_hold, ifid_hold, idex_bubble, ifid_flush, idex_flush, exmem_flush;
  logic [1:0] fwd_a, fwd_b, state_o;
  logic       halted;
`ifdef PIPE_PERF_EN
  logic [31:0] cyc_cnt, stall_cnt, flush_cnt;
`endif

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .REG_AW(5)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_halt      (id_halt),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .branch_taken (branch_taken),
    .pc_hold      (pc_hold),
    .ifid_hold    (ifid_hold),
    .idex_bubble  (idex_bubble),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .halted       (halted),
    .state_o      (state_o)
`ifdef PIPE_PERF_EN
    ,
    .cyc_cnt      (cyc_cnt),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  function automatic string fmt(out_t o);
    return $sformatf("pc=%b ifh=%b bub=%b fl=%b%b%b fa=%b fb=%b st=%0d h=%b",
                     o.pc_hold, o.ifid_hold, o.idex_bubble, o.ifid_flush,
                     o.idex_flush, o.exmem_flush, o.fwd_a, o.fwd_b, o.state, o.halted);
  endfunction

  function automatic out_t sample();
    out_t o;
    o = '{pc_hold, ifid_hold, idex_bubble, ifid_flush, idex_flush, exmem_flush,
          fwd_a, fwd_b, state_o, halted};
    return o;
  endfunction

  task automatic chk_out(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- builders ----------------
  function automatic in_t mk_in(
    input int rs, input int rt, input bit urs, input bit urt, input bit halt,
    input int exrd, input bit exwe, input bit exmr, input int memrd, input bit memwe,
    input int wbrd, input bit wbwe, input bit br);
    in_t i;
    i.id_rs = 5'(rs);  i.id_rt = 5'(rt);  i.id_use_rs = urs;  i.id_use_rt = urt;
    i.id_halt = halt;  i.ex_rd = 5'(exrd); i.ex_regwrite = exwe; i.ex_memread = exmr;
    i.mem_rd = 5'(memrd); i.mem_regwrite = memwe; i.wb_rd = 5'(wbrd);
    i.wb_regwrite = wbwe; i.branch_taken = br;
    return i;
  endfunction

  function automatic out_t mk_out(
    input bit pc, input bit ifh, input bit bub, input bit f1, input bit f2, input bit f3,
    input int fa, input int fb, input int st, input bit h);
    out_t o;
    o.pc_hold = pc; o.ifid_hold = ifh; o.idex_bubble = bub;
    o.ifid_flush = f1; o.idex_flush = f2; o.exmem_flush = f3;
    o.fwd_a = 2'(fa); o.fwd_b = 2'(fb); o.state = 2'(st); o.halted = h;
    return o;
  endfunction

  // ---------------- reference model ----------------
  // Mode: 0 running, 1 draining (drain_left cycles to go), 2 halted.
  int m_mode = 0;
  int m_left = 0;

  function automatic int ref_fwd(input int src, input in_t i);
    if (i.mem_regwrite && i.mem_rd != 0 && int'(i.mem_rd) == src) return 1;
    if (i.wb_regwrite && i.wb_rd != 0 && int'(i.wb_rd) == src) return 2;
    return 0;
  endfunction

  function automatic bit ref_load_use(input in_t i);
    if (!i.ex_memread || i.ex_rd == 0) return 0;
    return (i.id_use_rs && i.ex_rd == i.id_rs) || (i.id_use_rt && i.ex_rd == i.id_rt);
  endfunction

  function automatic out_t model_out(input in_t i);
    bit lu;
    int fa, fb;
    lu = ref_load_use(i);
    fa = ref_fwd(int'(i.id_rs), i);
    fb = ref_fwd(int'(i.id_rt), i);
    if (m_mode == 2) return mk_out(1, 1, 1, 0, 0, 0, 0, 0, 2, 1);
    if (m_mode == 1) begin
      if (i.branch_taken) return mk_out(0, 0, 0, 1, 1, 1, fa, fb, 1, 0);
      return mk_out(1, 0, 0, 1, 0, 0, fa, fb, 1, 0);
    end
    if (i.branch_taken) return mk_out(0, 0, 0, 1, 1, 1, fa, fb, 0, 0);
    if (lu) return mk_out(1, 1, 1, 0, 0, 0, fa, fb, 0, 0);
    return mk_out(0, 0, 0, 0, 0, 0, fa, fb, 0, 0);
  endfunction

  task automatic model_step(input in_t i);
    if (m_mode == 0) begin
      if (i.id_halt && !i.branch_taken && !ref_load_use(i)) begin
        m_mode = 1;
        m_left = 3;
      end
    end else if (m_mode == 1) begin
      if (i.branch_taken) begin
        m_mode = 0;
      end else begin
        m_left--;
        if (m_left == 0) m_mode = 2;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input in_t i);
    id_rs = i.id_rs; id_rt = i.id_rt; id_use_rs = i.id_use_rs; id_use_rt = i.id_use_rt;
    id_halt = i.id_halt; ex_rd = i.ex_rd; ex_regwrite = i.ex_regwrite;
    ex_memread = i.ex_memread; mem_rd = i.mem_rd; mem_regwrite = i.mem_regwrite;
    wb_rd = i.wb_rd; wb_regwrite = i.wb_regwrite; branch_taken = i.branch_taken;
  endtask

  // Drive inputs just after a posedge and move to the sampling point (negedge).
  task automatic apply(input in_t i);
    drive(i);
    @(negedge CLK);
  endtask

  // Commit the cycle: update the model and step past the next posedge.
  task automatic advance(input in_t i);
    model_step(i);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    drive('0);
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    m_mode = 0;
    m_left = 0;
  endtask

  function automatic in_t rand_in(input bit allow_halt);
    in_t r;
    r = mk_in($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), allow_halt && ($urandom_range(0, 9) == 0),
              $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 7), 1'($urandom_range(0, 1)),
              $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
    return r;
  endfunction

  // ---------------- test ----------------
  vec_t vecs[9];
  in_t  zero_in;
  in_t  cur;
  out_t halted_exp;
  int   halted_age;

  initial begin
    zero_in    = '0;
    halted_exp = mk_out(1, 1, 1, 0, 0, 0, 0, 0, 2, 1);

    //              rs rt urs urt h exrd we mr memrd we wbrd we br
    vecs[0] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0,0,0,0,0,0,0,0,0,0)};
    vecs[1] = '{mk_in(8, 0, 1, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0), mk_out(1,1,1,0,0,0,0,0,0,0)};
    vecs[2] = '{mk_in(0, 9, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0), mk_out(0,0,0,0,0,0,0,0,0,0)};
    vecs[3] = '{mk_in(0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0), mk_out(0,0,0,0,0,0,0,0,0,0)};
    vecs[4] = '{mk_in(3, 5, 1, 1, 0, 0, 0, 0, 5, 1, 5, 1, 0), mk_out(0,0,0,0,0,0,0,1,0,0)};
    vecs[5] = '{mk_in(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0), mk_out(0,0,0,0,0,0,0,0,0,0)};
    vecs[6] = '{mk_in(7, 0, 1, 0, 0, 0, 0, 0, 7, 0, 7, 1, 0), mk_out(0,0,0,0,0,0,2,0,0,0)};
    vecs[7] = '{mk_in(8, 0, 1, 0, 0, 8, 1, 1, 0, 0, 0, 0, 1), mk_out(0,0,0,1,1,1,0,0,0,0)};
    vecs[8] = '{mk_in(6, 4, 1, 1, 0, 0, 0, 0, 4, 1, 6, 1, 0), mk_out(0,0,0,0,0,0,2,1,0,0)};

    // Reset state, sampled while reset is still asserted.
    drive(zero_in);
    @(negedge CLK);
    chk_out("reset", sample(), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge CLK);
    #1;
    RST_N = 1'b1;

    // Table of single-cycle vectors, all in RUN.
    foreach (vecs[k]) begin
      apply(vecs[k].in);
      chk_out($sformatf("vec%0d", k), sample(), vecs[k].exp);
      advance(vecs[k].in);
    end

    // Load-use: one stall cycle, then the load sits in MEM and is forwarded.
    cur = mk_in(8, 0, 1, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0);
    apply(cur);
    chk_out("lu_stall", sample(), mk_out(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    advance(cur);
    cur = mk_in(8, 0, 1, 0, 0, 0, 0, 0, 8, 1, 0, 0, 0);
    apply(cur);
    chk_out("lu_fwd", sample(), mk_out(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    advance(cur);

    // Halt with a pending load-use stalls first and stays in RUN.
    cur = mk_in(8, 0, 1, 0, 1, 8, 1, 1, 0, 0, 0, 0, 0);
    apply(cur);
    chk_out("halt_lu", sample(), mk_out(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    advance(cur);
    apply(zero_in);
    chk_val("halt_lu_run", 32'(state_o), 32'd0);
    advance(zero_in);

    // Halt drain: three DRAIN cycles, then HALTED that ignores inputs.
    cur = mk_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(cur);
    chk_out("halt_dec", sample(), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    advance(cur);
    for (int c = 0; c < 3; c++) begin
      apply(zero_in);
      chk_out($sformatf("drain%0d", c), sample(), mk_out(1, 0, 0, 1, 0, 0, 0, 0, 1, 0));
      advance(zero_in);
    end
    for (int c = 0; c < 20; c++) begin
      cur = rand_in(1'b1);
      apply(cur);
      chk_out($sformatf("halted%0d", c), sample(), halted_exp);
      advance(cur);
    end

    // Asynchronous reset out of HALTED.
    #1 RST_N = 1'b0;
    #1;
    chk_val("rst_halted_h", 32'(halted), 32'd0);
    chk_val("rst_halted_st", 32'(state_o), 32'd0);
    #1 RST_N = 1'b1;
    m_mode = 0;
    @(posedge CLK);
    #1;

    // Branch on the second DRAIN cycle squashes the halt.
    cur = mk_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(cur);
    advance(cur);
    apply(zero_in);
    chk_val("bd_drain1", 32'(state_o), 32'd1);
    advance(zero_in);
    cur = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    apply(cur);
    chk_out("bd_flush", sample(), mk_out(0, 0, 0, 1, 1, 1, 0, 0, 1, 0));
    advance(cur);
    for (int c = 0; c < 5; c++) begin
      apply(zero_in);
      chk_out($sformatf("bd_run%0d", c), sample(), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      advance(zero_in);
    end

    // Reset pulse in the middle of the second DRAIN cycle.
    cur = mk_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(cur);
    advance(cur);
    apply(zero_in);
    advance(zero_in);
    drive(zero_in);
    #1 RST_N = 1'b0;
    #1;
    chk_val("rst_drain_st", 32'(state_o), 32'd0);
    chk_val("rst_drain_h", 32'(halted), 32'd0);
`ifdef PIPE_PERF_EN
    chk_val("rst_cyc", cyc_cnt, 32'd0);
    chk_val("rst_stall", stall_cnt, 32'd0);
    chk_val("rst_flush", flush_cnt, 32'd0);
`endif
    #1 RST_N = 1'b1;
    m_mode = 0;
    m_left = 0;
    @(posedge CLK);
    #1;
    apply(zero_in);
    chk_out("rst_drain_after", sample(), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    advance(zero_in);

    // Randomized traffic against the reference model.
    halted_age = 0;
    for (int c = 0; c < 400; c++) begin
      cur = rand_in(1'b1);
      apply(cur);
      chk_out($sformatf("rand%0d", c), sample(), model_out(cur));
      advance(cur);
      if (m_mode == 2) halted_age++;
      if (halted_age > 3) begin
        halted_age = 0;
        do_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
